// File: rtl/sensor_reg_pkg.sv
// sensor_reg_pkg: register offsets, STATUS field positions and channel status type
package sensor_reg_pkg;
    localparam logic [31:0] CTRL_OFS   = 32'h00;
    localparam logic [31:0] STATUS_OFS = 32'h04;
    localparam logic [31:0] DATA_OFS   = 32'h08;
    localparam int FRESH_LSB = 0;
    localparam int OVF_LSB   = 8;
    localparam int STALE_LSB = 16;
    typedef struct packed {
        logic fresh;
        logic overflow;
        logic stale;
    } chan_status_t;
endpackage

// File: rtl/sensor_channel.sv
// sensor_channel: one channel's capture register, fresh/overflow flags and stale counter
module sensor_channel
    import sensor_reg_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int STALE_LIMIT = 1000
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              enable,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic              rd_clr,
    input  logic              ovf_clr,
    output logic              ready,
    output logic [DATA_W-1:0] sample,
    output chan_status_t      status
);
    localparam int CW = $clog2(STALE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALE_LIMIT);
    logic [CW-1:0] cnt;
    logic cap;
    assign ready = enable;
    assign cap   = valid & enable;
    // a capture beats both read-clear of fresh and W1C of overflow
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sample <= '0;
            status <= '0;
            cnt    <= '0;
        end else begin
            if (cap) sample <= data;
            status.fresh    <= cap | (status.fresh & ~rd_clr);
            status.overflow <= (cap & status.fresh & ~rd_clr) | (status.overflow & ~ovf_clr);
            cnt             <= (cap | ~enable) ? '0 : (cnt == LIMIT ? cnt : cnt + 1'b1);
            status.stale    <= ~cap & enable & (status.stale | (cnt == LIMIT - 1'b1));
        end
    end
endmodule

// File: rtl/sensor_reg_bank.sv
// sensor_reg_bank: sensor capture bank with APB-decoded RegisterData; irq under SENSOR_IRQ_EN
module sensor_reg_bank
    import sensor_reg_pkg::*;
#(
    parameter int          NUM_SENSORS = 4,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int          STALE_LIMIT = 1000
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_SENSORS-1:0]        sens_valid,
    input  logic [NUM_SENSORS*DATA_W-1:0] sens_data,
    output logic [NUM_SENSORS-1:0]        sens_ready,
    input  logic [31:0]                   PADDR,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [31:0]                   PWDATA,
    output logic [31:0]                   RegisterData,
    output logic                          addr_err,
    output logic                          irq
);
    localparam logic [31:0] MAP_END = 32'(8 + 4 * NUM_SENSORS);
    logic [NUM_SENSORS-1:0] en, irq_mask, fresh_n, ovf_n, stale_n, rd_clr, ovf_clr;
    logic [DATA_W-1:0] samples [NUM_SENSORS];
    chan_status_t st [NUM_SENSORS];
    logic [31:0] offs, rdata;
    logic [2:0] ch;
    logic mapped, data_sel, wr, rd, unused_ok;
    assign offs      = PADDR - BASE_ADDR;
    assign mapped    = PADDR[1:0] == 2'b00 && offs < MAP_END;
    assign data_sel  = offs >= DATA_OFS;
    assign ch        = 3'((offs - DATA_OFS) >> 2);
    assign wr        = PSEL & PENABLE & PWRITE & mapped;
    assign rd        = PSEL & PENABLE & ~PWRITE & mapped;
    assign ovf_clr   = (wr && offs == STATUS_OFS) ? PWDATA[OVF_LSB +: NUM_SENSORS] : '0;
    assign unused_ok = ^PWDATA;
    always_comb begin
        rd_clr = '0;
        for (int i = 0; i < NUM_SENSORS; i++) rd_clr[i] = rd & data_sel & (ch == 3'(i));
    end
    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
        sensor_channel #(.DATA_W(DATA_W), .STALE_LIMIT(STALE_LIMIT)) u_ch (
            .PCLK(PCLK), .PRESET(PRESET), .enable(en[i]), .valid(sens_valid[i]),
            .data(sens_data[i*DATA_W +: DATA_W]), .rd_clr(rd_clr[i]), .ovf_clr(ovf_clr[i]),
            .ready(sens_ready[i]), .sample(samples[i]), .status(st[i])
        );
        assign fresh_n[i] = st[i].fresh;
        assign ovf_n[i]   = st[i].overflow;
        assign stale_n[i] = st[i].stale;
    end
    always_comb begin
        rdata = '0;
        if (offs == CTRL_OFS) begin
            rdata[15:0] = {8'(irq_mask), 8'(en)};
        end else if (offs == STATUS_OFS) begin
            rdata[FRESH_LSB +: 8] = 8'(fresh_n);
            rdata[OVF_LSB +: 8]   = 8'(ovf_n);
            rdata[STALE_LSB +: 8] = 8'(stale_n);
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) if (ch == 3'(i)) rdata = 32'(samples[i]);
        end
    end
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            en           <= '0;
            RegisterData <= '0;
            addr_err     <= 1'b0;
        end else begin
            if (wr && offs == CTRL_OFS) en <= PWDATA[NUM_SENSORS-1:0];
            RegisterData <= mapped ? rdata : '0;
            addr_err     <= PSEL & ~mapped;
        end
    end
`ifdef SENSOR_IRQ_EN
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && offs == CTRL_OFS) irq_mask <= PWDATA[8 +: NUM_SENSORS];
            irq <= |(fresh_n & irq_mask);
        end
    end
`else
    assign irq_mask = '0;
    assign irq      = 1'b0;
`endif
endmodule

// File: tb/tb_sensor_reg_bank.sv
// tb_sensor_reg_bank: directed table, corner sequences and randomized model check of sensor_reg_bank
module tb_sensor_reg_bank;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam int LIMIT = 1000;
    localparam logic [31:0] B = 32'h0000_0100;
    localparam logic [7:0] CHM = 8'h0F;
`ifdef SENSOR_IRQ_EN
    localparam logic [31:0] CTRL_101 = 32'h101;
`else
    localparam logic [31:0] CTRL_101 = 32'h001;
`endif

    logic PCLK, PRESET, PSEL, PENABLE, PWRITE, addr_err, irq;
    logic [NS-1:0] sens_valid, sens_ready;
    logic [NS*DW-1:0] sens_data;
    logic [31:0] PADDR, PWDATA, RegisterData;

    sensor_reg_bank #(.NUM_SENSORS(NS), .DATA_W(DW), .BASE_ADDR(B), .STALE_LIMIT(LIMIT)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .sens_valid(sens_valid), .sens_data(sens_data),
        .sens_ready(sens_ready), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .RegisterData(RegisterData),
        .addr_err(addr_err), .irq(irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    // reference model: plain flag vectors and idle-cycle counts
    logic [7:0] m_en, m_mask, m_fresh, m_ovf, m_stale;
    int m_idle [NS];
    logic [31:0] m_data [NS];

    function automatic logic is_mapped(input logic [31:0] a);
        logic [31:0] off;
        off = a - B;
        return a[1:0] == 2'b00 && off < 32'(8 + 4 * NS);
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [31:0] off;
        off = a - B;
        if (!is_mapped(a)) return 32'h0;
        if (off == 0) return {16'h0, m_mask, m_en};
        if (off == 4) return {8'h0, m_stale, m_ovf, m_fresh};
        return m_data[int'((off - 8) / 4)];
    endfunction

    task automatic step(input string tag);
        logic [31:0] e_rd, off;
        logic e_err, e_irq, mp, cap, rdclr, w1c;
        off   = PADDR - B;
        mp    = is_mapped(PADDR);
        e_rd  = mread(PADDR);
        e_err = PSEL & ~mp;
`ifdef SENSOR_IRQ_EN
        e_irq = |(m_fresh & m_mask);
`else
        e_irq = 1'b0;
`endif
        if (PRESET) begin
            e_rd = 0; e_err = 0; e_irq = 0;
            m_en = 0; m_mask = 0; m_fresh = 0; m_ovf = 0; m_stale = 0;
            for (int i = 0; i < NS; i++) begin m_idle[i] = 0; m_data[i] = 0; end
        end else begin
            for (int i = 0; i < NS; i++) begin
                cap   = sens_valid[i] & m_en[i];
                rdclr = PSEL & PENABLE & ~PWRITE & mp && off == 32'(8 + 4 * i);
                w1c   = PSEL & PENABLE & PWRITE & mp && off == 4 && PWDATA[8 + i];
                if (cap && m_fresh[i] && !rdclr) m_ovf[i] = 1'b1;
                else if (w1c) m_ovf[i] = 1'b0;
                if (cap) m_fresh[i] = 1'b1;
                else if (rdclr) m_fresh[i] = 1'b0;
                if (cap) m_data[i] = sens_data[i*DW +: DW];
                if (!m_en[i] || cap) m_idle[i] = 0;
                else if (m_idle[i] < LIMIT) m_idle[i]++;
                m_stale[i] = m_en[i] && m_idle[i] >= LIMIT;
            end
            if (PSEL & PENABLE & PWRITE & mp && off == 0) begin
                m_en = PWDATA[7:0] & CHM;
`ifdef SENSOR_IRQ_EN
                m_mask = PWDATA[15:8] & CHM;
`endif
            end
        end
        @(posedge PCLK);
        #1;
        chk({tag, "_rdata"}, RegisterData, e_rd);
        chk({tag, "_err"}, 32'(addr_err), 32'(e_err));
        chk({tag, "_irq"}, 32'(irq), 32'(e_irq));
        chk({tag, "_ready"}, 32'(sens_ready), 32'(m_en[NS-1:0]));
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        sel, en, wr;
        logic [31:0] wdata;
        logic [NS-1:0] valid;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tv [$];

    function automatic void add(input string n, input logic [31:0] a, input logic s, input logic e,
                                input logic w, input logic [31:0] wd, input logic [NS-1:0] v,
                                input logic [31:0] d, input logic [31:0] er, input logic ee);
        tv.push_back('{n, a, s, e, w, wd, v, d, er, ee});
    endfunction

    task automatic idle_bus(input logic [31:0] a);
        PADDR = a; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = 0; sens_valid = 0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input string tag);
        PADDR = a; PSEL = 1; PENABLE = 1; PWRITE = 1; PWDATA = d; sens_valid = 0;
        step(tag);
    endtask

    initial begin
        PRESET = 1; sens_data = '0;
        idle_bus(32'h0);
        step("rst0");
        step("rst1");
        PRESET = 0;

        add("rst_ctrl",   B + 32'h00, 1, 0, 0, 0,        4'h0, 0,            32'h0,         0);
        add("rst_status", B + 32'h04, 1, 0, 0, 0,        4'h0, 0,            32'h0,         0);
        add("rst_data0",  B + 32'h08, 1, 0, 0, 0,        4'h0, 0,            32'h0,         0);
        add("wr_ctrl",    B + 32'h00, 1, 1, 1, 32'h1,    4'h0, 0,            32'h0,         0);
        add("rd_ctrl",    B + 32'h00, 1, 0, 0, 0,        4'h0, 0,            32'h1,         0);
        add("cap_beef",   B + 32'h08, 0, 0, 0, 0,        4'h1, 32'hDEADBEEF, 32'h0,         0);
        add("data_beef",  B + 32'h08, 0, 0, 0, 0,        4'h0, 0,            32'hDEADBEEF,  0);
        add("st_fresh",   B + 32'h04, 0, 0, 0, 0,        4'h0, 0,            32'h1,         0);
        add("rdclr_beef", B + 32'h08, 1, 1, 0, 0,        4'h0, 0,            32'hDEADBEEF,  0);
        add("st_clear",   B + 32'h04, 0, 0, 0, 0,        4'h0, 0,            32'h0,         0);
        add("cap_11",     B + 32'h04, 0, 0, 0, 0,        4'h1, 32'h11,       32'h0,         0);
        add("cap_22",     B + 32'h04, 0, 0, 0, 0,        4'h1, 32'h22,       32'h1,         0);
        add("data_22",    B + 32'h08, 0, 0, 0, 0,        4'h0, 0,            32'h22,        0);
        add("st_101",     B + 32'h04, 0, 0, 0, 0,        4'h0, 0,            32'h101,       0);
        add("w1c_ovf",    B + 32'h04, 1, 1, 1, 32'h100,  4'h0, 0,            32'h101,       0);
        add("st_w1c",     B + 32'h04, 0, 0, 0, 0,        4'h0, 0,            32'h1,         0);
        add("cap_rdclr",  B + 32'h08, 1, 1, 0, 0,        4'h1, 32'h33,       32'h22,        0);
        add("st_capwin",  B + 32'h04, 0, 0, 0, 0,        4'h0, 0,            32'h1,         0);
        add("data_33",    B + 32'h08, 0, 0, 0, 0,        4'h0, 0,            32'h33,        0);
        add("unm_40",     B + 32'h40, 1, 0, 0, 0,        4'h0, 0,            32'h0,         1);
        add("mis_02",     B + 32'h02, 1, 0, 0, 0,        4'h0, 0,            32'h0,         1);
        add("unm_nosel",  B + 32'h40, 0, 0, 0, 0,        4'h0, 0,            32'h0,         0);
        add("idle_addr",  32'h0,      1, 0, 0, 0,        4'h0, 0,            32'h0,         1);
        add("wr_data_ign",B + 32'h08, 1, 1, 1, 32'hFFFF, 4'h0, 0,            32'h33,        0);
        add("data_kept",  B + 32'h08, 0, 0, 0, 0,        4'h0, 0,            32'h33,        0);
        add("wr_ctrl101", B + 32'h00, 1, 1, 1, 32'h101,  4'h0, 0,            32'h1,         0);
        add("rd_ctrl101", B + 32'h00, 1, 0, 0, 0,        4'h0, 0,            CTRL_101,      0);
        add("rdclr_33",   B + 32'h08, 1, 1, 0, 0,        4'h0, 0,            32'h33,        0);
        add("data3_edge", B + 32'h14, 1, 0, 0, 0,        4'h0, 0,            32'h0,         0);
        add("past_end",   B + 32'h18, 1, 0, 0, 0,        4'h0, 0,            32'h0,         1);

        foreach (tv[k]) begin
            PADDR = tv[k].addr; PSEL = tv[k].sel; PENABLE = tv[k].en; PWRITE = tv[k].wr;
            PWDATA = tv[k].wdata; sens_valid = tv[k].valid;
            sens_data = '0; sens_data[DW-1:0] = tv[k].d;
            step(tv[k].name);
            chk({tv[k].name, "_vec"}, RegisterData, tv[k].exp_rd);
            chk({tv[k].name, "_vecerr"}, 32'(addr_err), 32'(tv[k].exp_err));
        end

        // stale: ch1 enabled, never captured
        apb_write(B, 32'h103, "en_ch1");
        idle_bus(B + 32'h04);
        for (int j = 0; j < LIMIT; j++) step("stale_run");
        chk("stale_pre", 32'(RegisterData[17]), 32'h0);
        step("stale_run");
        chk("stale_set", 32'(RegisterData[17]), 32'h1);
        sens_valid = 4'h2; sens_data[2*DW-1:DW] = 32'hCAFE_F00D;
        step("cap_ch1");
        sens_valid = 4'h0;
        step("after_cap_ch1");
        chk("stale_clr", 32'(RegisterData[17]), 32'h0);
        chk("ready1_on", 32'(sens_ready[1]), 32'h1);
        apb_write(B, 32'h101, "dis_ch1");
        chk("ready1_off", 32'(sens_ready[1]), 32'h0);

        // randomized traffic, including occasional mid-run reset
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 9))
                0: PADDR = B;
                1: PADDR = B + 32'h04;
                2: PADDR = B + 32'h08;
                3: PADDR = B + 32'h0C;
                4: PADDR = B + 32'h10;
                5: PADDR = B + 32'h14;
                6: PADDR = B + 32'h18;
                7: PADDR = B + 32'h02;
                8: PADDR = 32'h0;
                default: PADDR = $urandom;
            endcase
            PSEL = ($urandom_range(0, 3) != 0);
            PENABLE = $urandom_range(0, 1) == 1;
            PWRITE = $urandom_range(0, 2) == 0;
            PWDATA = $urandom;
            sens_valid = NS'($urandom);
            for (int i = 0; i < NS; i++) sens_data[i*DW +: DW] = $urandom;
            PRESET = $urandom_range(0, 99) == 0;
            step("rand");
        end
        PRESET = 0;
        idle_bus(32'h0);
        step("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sensor_reg_bank.md
Name: sensor_reg_bank

Overview:
- Sensor-side register bank that feeds the APB read slave's RegisterData input.
- Captures samples from up to 8 sensor channels over valid/ready handshakes.
- Holds per-channel control and status: enable, fresh, overflow and stale flags.
- Decodes PADDR into a registered 32-bit RegisterData word, and accepts APB control writes.

Parameters:
- NUM_SENSORS, 4, number of sensor channels (1..8).
- DATA_W, 32, sensor sample width (≤32, zero-extended on readout).
- BASE_ADDR, 32'h0000_0100, byte base of the register map (non-zero; PADDR 0 is the APB idle address).
- STALE_LIMIT, 1000, cycles without a capture before a channel is flagged stale.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous active-high reset.
- sens_valid  in  NUM_SENSORS  per-channel sample valid.
- sens_data  in  NUM_SENSORS*DATA_W  packed samples; channel i at [i*DATA_W +: DATA_W].
- sens_ready  out  NUM_SENSORS  per-channel ready.
- PADDR  in  32  APB address.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB direction.
- PWDATA  in  32  APB write data.
- RegisterData  out  32  registered word for the address currently on PADDR.
- addr_err  out  1  registered; PADDR was unmapped or misaligned while PSEL was high.
- irq  out  1  fresh-data interrupt (SENSOR_IRQ_EN only).

Behaviour:
- Clock and reset: single clock PCLK; reset PRESET is synchronous, active-high.
- Reset state: all internal registers cleared; RegisterData=0, addr_err=0, irq=0, sens_ready=0.
- Register map (byte offsets from BASE_ADDR):
  - 0x00 CTRL: [7:0] enable mask, [15:8] irq mask; read/write.
  - 0x04 STATUS: [7:0] fresh, [15:8] overflow, [23:16] stale; read-only, except overflow bits are write-1-to-clear.
  - 0x08+4*i DATA_i: last captured sample of channel i; read-only, writes ignored.
- Mapped addresses: PADDR[1:0]==0 and 0 ≤ PADDR-BASE_ADDR < 8+4*NUM_SENSORS. Bits for channels ≥ NUM_SENSORS read 0 and are not writable.
- Read latency:
  - RegisterData updates one cycle after PADDR, every cycle, regardless of PSEL.
  - Unmapped address → RegisterData=0.
  - addr_err = PSEL & unmapped, registered with the same one-cycle latency.
- Write: takes effect on the cycle with PSEL&PENABLE&PWRITE at a mapped address. Unmapped writes are dropped.
- Read-clear: the cycle with PSEL&PENABLE&!PWRITE at DATA_i clears fresh_i.
- Capture handshake:
  - sens_ready_i = enable_i (combinational from the CTRL register).
  - On sens_valid_i & sens_ready_i: DATA_i <= sample, fresh_i <= 1, stale counter_i <= 0, stale_i <= 0.
  - If fresh_i was already 1 and is not being read-cleared in that cycle: overflow_i <= 1 (sticky).
- Simultaneous events:
  - Capture and read-clear of the same channel in one cycle: capture wins, fresh stays 1, no overflow. The read returns the old sample.
  - Capture and W1C of overflow_i in one cycle: the set wins.
- Stale counter, per enabled channel:
  - Width $clog2(STALE_LIMIT+1).
  - Increments each cycle without a capture and saturates at STALE_LIMIT.
  - Reaching STALE_LIMIT sets stale_i.
- Disabling a channel (enable_i 1→0): sens_ready_i drops the next cycle. Counter held at 0, stale_i cleared. DATA_i, fresh_i and overflow_i retained.
- Reset mid-operation: PRESET on any cycle overrides captures and writes in that cycle.

Optional Feature:
- Macro: SENSOR_IRQ_EN.
- Defined:
  - irq is registered, equal to |(fresh & irq_mask), with one cycle latency.
  - CTRL[15:8] is writable.
- Undefined:
  - irq is tied 0.
  - CTRL[15:8] reads 0 and writes to it are ignored.

Decomposition:
- Package sensor_reg_pkg:
  - offset constants CTRL_OFS=0x00, STATUS_OFS=0x04, DATA_OFS=0x08.
  - STATUS field LSB constants (0, 8, 16).
  - typedef for a channel status struct {fresh, overflow, stale}.
- One sub-module, sensor_channel: per-channel capture register, fresh/overflow/stale logic and saturating counter; instantiated NUM_SENSORS times via generate.

Test Plan:
- Reset, then read CTRL/STATUS/DATA_0 → all 0; sens_ready=0; irq=0.
- Write CTRL=0x0000_0001; ch0 valid with 0xDEAD_BEEF → DATA_0 reads 0xDEAD_BEEF one cycle after PADDR=BASE+0x08; STATUS=0x1; APB read of DATA_0 clears STATUS to 0.
- Two ch0 captures (0x11, then 0x22) without a read → DATA_0=0x22, STATUS=0x101. Write STATUS=0x100 → STATUS=0x1. Capture on the same cycle as a DATA_0 read-clear → fresh stays 1, overflow stays 0.
- Enable ch1 with STALE_LIMIT=1000 and no captures → STATUS[17]=1 on cycle 1000. A capture clears it. Disabling ch1 drops sens_ready[1] one cycle later.
- PADDR=BASE+0x40 or BASE+0x02 with PSEL=1 → RegisterData=0, addr_err=1 next cycle. PSEL=0 → addr_err=0.
- SENSOR_IRQ_EN defined: CTRL=0x0101, ch0 capture → irq=1 one cycle after fresh sets; read DATA_0 → irq=0. SENSOR_IRQ_EN undefined → irq stays 0 and CTRL reads 0x0001.
